// File: rtl/colour_track_pkg.sv
// Shared types and widths for the colour frame tracker.
package colour_track_pkg;

  localparam int PIX_W = 17;
  localparam int SUM_W = 19;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    CLOSE  = 2'd2
  } track_state_t;

  // Direction of the transition the current average argues for
  typedef enum logic [1:0] {
    CAND_NONE = 2'd0,
    CAND_UP   = 2'd1,
    CAND_DOWN = 2'd2
  } cand_t;

endpackage

// File: rtl/frame_avg4.sv
// Four-slot frame window with a registered moving average and update pulse.
module frame_avg4
  import colour_track_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             sample_en,
  input  logic [PIX_W-1:0] sample,
  output logic [PIX_W-1:0] avg,
  output logic             avg_valid
);

  logic [PIX_W-1:0] slot0, slot1, slot2, slot3;
  logic [SUM_W-1:0] next_sum;

  // Sum of the window as it will be once the new sample has shifted in
  always_comb begin
    next_sum = SUM_W'(sample) + SUM_W'(slot0) + SUM_W'(slot1) + SUM_W'(slot2);
  end

  // Window shift, truncated average and one-cycle valid pulse
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      slot0     <= '0;
      slot1     <= '0;
      slot2     <= '0;
      slot3     <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
    end else if (sample_en) begin
      slot0     <= sample;
      slot1     <= slot0;
      slot2     <= slot1;
      slot3     <= slot2;
      avg       <= PIX_W'(next_sum >> 2);
      avg_valid <= 1'b1;
    end else begin
      avg_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/colour_frame_tracker.sv
// Samples per-frame colour counts, smooths them and classifies the target
// as absent, tracked or close with confirmation and a camera-stall fallback.
module colour_frame_tracker
  import colour_track_pkg::*;
#(
  parameter int LOST_THRESH    = 200,
  parameter int FAR_THRESH     = 4800,
  parameter int NEAR_THRESH    = 9600,
  parameter int CONFIRM_FRAMES = 3,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sop,
  input  logic [16:0] colour_pixels,
  input  logic        clear,
  output logic [16:0] avg_pixels,
  output logic        avg_valid,
  output logic [1:0]  state,
  output logic        target_seen,
  output logic        target_close,
  output logic        drive_enable,
  output logic        stale
);

  localparam int               TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [PIX_W-1:0] LOST_T    = PIX_W'(LOST_THRESH);
  localparam logic [PIX_W-1:0] FAR_T     = PIX_W'(FAR_THRESH);
  localparam logic [PIX_W-1:0] NEAR_T    = PIX_W'(NEAR_THRESH);
  localparam logic [3:0]       CONFIRM_N = 4'(CONFIRM_FRAMES);

  logic             sop_d, discard, frame_edge, sample_en, timeout_hit, avg_clear;
  logic [TMR_W-1:0] timer;
  track_state_t     cur_state, next_state, goal;
  cand_t            cand, prev_cand, next_cand;
  logic [3:0]       confirm, next_confirm, bumped;

  assign frame_edge  = sop & ~sop_d;
  assign sample_en   = frame_edge & ~clear & ~discard;
  // A frame edge in the expiry cycle restarts the timer instead of timing out
  assign timeout_hit = ~frame_edge & (timer == TMR_LAST);
  assign avg_clear   = clear | timeout_hit;
  assign state       = cur_state;

  frame_avg4 u_avg (
    .clk       (clk),
    .reset     (reset),
    .clear     (avg_clear),
    .sample_en (sample_en),
    .sample    (colour_pixels),
    .avg       (avg_pixels),
    .avg_valid (avg_valid)
  );

  // Edge history, partial-frame discard, stall timer and stale flag
  always_ff @(posedge clk) begin
    if (reset) begin
      sop_d   <= 1'b0;
      discard <= 1'b1;
      timer   <= '0;
      stale   <= 1'b0;
    end else begin
      sop_d <= sop;
      if (clear) discard <= 1'b1;
      else if (frame_edge) discard <= 1'b0;
      if (frame_edge) timer <= '0;
      else if (timer != TMR_MAX) timer <= timer + TMR_W'(1);
      if (sample_en) stale <= 1'b0;
      else if (timeout_hit) stale <= 1'b1;
    end
  end

  // Candidate transition and its destination for the current average
  always_comb begin
    cand = CAND_NONE;
    goal = cur_state;
    case (cur_state)
      SEARCH: begin
        if (avg_pixels >= FAR_T) begin cand = CAND_UP; goal = TRACK; end
        else begin cand = CAND_NONE; goal = SEARCH; end
      end
      TRACK: begin
        if (avg_pixels >= NEAR_T) begin cand = CAND_UP; goal = CLOSE; end
        else if (avg_pixels < LOST_T) begin cand = CAND_DOWN; goal = SEARCH; end
        else begin cand = CAND_NONE; goal = TRACK; end
      end
      CLOSE: begin
        if (avg_pixels < FAR_T) begin cand = CAND_DOWN; goal = TRACK; end
        else begin cand = CAND_NONE; goal = CLOSE; end
      end
      default: begin cand = CAND_NONE; goal = SEARCH; end
    endcase
  end

  // Confirmation counting; a transition needs CONFIRM_FRAMES matching averages in a row
  always_comb begin
    bumped       = (cand == prev_cand) ? confirm + 4'd1 : 4'd1;
    next_state   = cur_state;
    next_confirm = confirm;
    next_cand    = prev_cand;
    if (!avg_valid) begin
      next_confirm = confirm;
    end else if (cand == CAND_NONE) begin
      next_confirm = 4'd0;
      next_cand    = CAND_NONE;
    end else if (bumped == CONFIRM_N) begin
      next_state   = goal;
      next_confirm = 4'd0;
      next_cand    = CAND_NONE;
    end else begin
      next_confirm = bumped;
      next_cand    = cand;
    end
  end

  // State register with registered output decode
  always_ff @(posedge clk) begin
    if (reset || clear || timeout_hit) begin
      cur_state    <= SEARCH;
      confirm      <= 4'd0;
      prev_cand    <= CAND_NONE;
      target_seen  <= 1'b0;
      target_close <= 1'b0;
      drive_enable <= 1'b0;
    end else begin
      cur_state    <= next_state;
      confirm      <= next_confirm;
      prev_cand    <= next_cand;
      target_seen  <= (next_state != SEARCH);
      target_close <= (next_state == CLOSE);
      drive_enable <= (next_state == TRACK);
    end
  end

endmodule

// File: tb/tb_colour_frame_tracker.sv
// Table-driven, directed and randomized checks against a frame-level model.
module tb_colour_frame_tracker;

  localparam int TO = 300, CONF = 3, LOST = 200, FAR = 4800, NEAR = 9600, GAP = 3;

  logic clk = 1'b0;
  logic reset, sop, clear;
  logic [16:0] colour_pixels, avg_pixels;
  logic avg_valid, target_seen, target_close, drive_enable, stale;
  logic [1:0] state;

  colour_frame_tracker #(
    .LOST_THRESH(LOST), .FAR_THRESH(FAR), .NEAR_THRESH(NEAR),
    .CONFIRM_FRAMES(CONF), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .sop(sop), .colour_pixels(colour_pixels), .clear(clear),
    .avg_pixels(avg_pixels), .avg_valid(avg_valid), .state(state),
    .target_seen(target_seen), .target_close(target_close),
    .drive_enable(drive_enable), .stale(stale)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int since;
  logic sop_q;

  // Cycles since the last sop rising edge, as seen by the bench
  always @(posedge clk) begin
    if (reset) begin
      since <= 0;
      sop_q <= 1'b0;
    end else begin
      sop_q <= sop;
      if (sop && !sop_q) since <= 0;
      else since <= since + 1;
    end
  end

  // Frame-level reference model
  int win[4];
  bit m_discard, m_stale;
  int m_state, m_cnt, m_want, m_avg;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_wipe();
    for (int i = 0; i < 4; i++) win[i] = 0;
    m_avg = 0; m_state = 0; m_cnt = 0; m_want = 0;
  endtask

  function automatic int model_frame(input int count);
    int want;
    if (m_discard) begin
      m_discard = 0;
      return 0;
    end
    for (int i = 3; i > 0; i--) win[i] = win[i-1];
    win[0] = count;
    m_avg = (win[0] + win[1] + win[2] + win[3]) / 4;
    m_stale = 0;
    want = m_state;
    if (m_state == 0 && m_avg >= FAR) want = 1;
    else if (m_state == 1 && m_avg >= NEAR) want = 2;
    else if (m_state == 1 && m_avg < LOST) want = 0;
    else if (m_state == 2 && m_avg < FAR) want = 1;
    if (want == m_state) m_cnt = 0;
    else begin
      if (m_cnt > 0 && want == m_want) m_cnt++;
      else m_cnt = 1;
      m_want = want;
      if (m_cnt == CONF) begin
        m_state = want;
        m_cnt = 0;
      end
    end
    return 1;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, " avg"}, avg_pixels, m_avg);
    chk({tag, " state"}, state, m_state);
    chk({tag, " seen"}, target_seen, (m_state != 0) ? 1 : 0);
    chk({tag, " close"}, target_close, (m_state == 2) ? 1 : 0);
    chk({tag, " drive"}, drive_enable, (m_state == 1) ? 1 : 0);
    chk({tag, " stale"}, stale, m_stale);
  endtask

  task automatic run_frame(input int count, input int hold, output int pulses, output int last_avg);
    colour_pixels = 17'(count);
    sop = 1'b1;
    pulses = 0;
    last_avg = -1;
    for (int i = 0; i < hold + GAP; i++) begin
      @(negedge clk);
      if (avg_valid) begin
        pulses++;
        last_avg = avg_pixels;
      end
      if (i == hold - 1) sop = 1'b0;
    end
  endtask

  task automatic frame_chk(input string tag, input int count, input int hold);
    int p, a, ep;
    run_frame(count, hold, p, a);
    ep = model_frame(count);
    chk({tag, " pulses"}, p, ep);
    if (ep == 1) chk({tag, " pulse_avg"}, a, m_avg);
    check_outputs(tag);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_wipe();
    m_discard = 1;
    check_outputs("clear");
  endtask

  task automatic clear_with_edge(input int count);
    int p;
    colour_pixels = 17'(count);
    sop = 1'b1;
    clear = 1'b1;
    p = 0;
    @(negedge clk);
    clear = 1'b0;
    if (avg_valid) p++;
    model_wipe();
    m_discard = 1;
    check_outputs("clr_edge");
    for (int i = 0; i <= GAP; i++) begin
      @(negedge clk);
      if (avg_valid) p++;
      if (i == 0) sop = 1'b0;
    end
    chk("clr_edge pulses", p, 0);
  endtask

  typedef struct {
    int count;
    int hold;
    int exp_pulses;
    int exp_avg;
    int exp_state;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int p, a, r;
    tbl[0]  = '{8000, 1, 0, 0, 0};
    tbl[1]  = '{8000, 5, 1, 2000, 0};
    tbl[2]  = '{8000, 2, 1, 4000, 0};
    tbl[3]  = '{8000, 1, 1, 6000, 0};
    tbl[4]  = '{8000, 1, 1, 8000, 0};
    tbl[5]  = '{8000, 1, 1, 8000, 1};
    tbl[6]  = '{30000, 1, 1, 13500, 1};
    tbl[7]  = '{0, 1, 1, 11500, 1};
    tbl[8]  = '{0, 1, 1, 9500, 1};
    tbl[9]  = '{30000, 1, 1, 15000, 1};
    tbl[10] = '{10000, 1, 1, 10000, 1};
    tbl[11] = '{10000, 1, 1, 12500, 2};
    tbl[12] = '{9000, 1, 1, 14750, 2};
    tbl[13] = '{5000, 1, 1, 8500, 2};
    tbl[14] = '{9000, 1, 1, 8250, 2};
    tbl[15] = '{5000, 1, 1, 7000, 2};
    tbl[16] = '{9000, 5, 1, 7000, 2};
    tbl[17] = '{5000, 1, 1, 7000, 2};

    reset = 1'b1; sop = 1'b0; clear = 1'b0; colour_pixels = 17'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    model_wipe();
    m_discard = 1;
    m_stale = 0;
    chk("reset avg_valid", avg_valid, 0);
    check_outputs("reset");

    // Fill, confirmation restart, long sop and hysteresis from constants
    for (int i = 0; i < 18; i++) begin
      run_frame(tbl[i].count, tbl[i].hold, p, a);
      r = model_frame(tbl[i].count);
      chk($sformatf("tbl%0d pulses", i), p, tbl[i].exp_pulses);
      chk($sformatf("tbl%0d avg", i), avg_pixels, tbl[i].exp_avg);
      chk($sformatf("tbl%0d state", i), state, tbl[i].exp_state);
      chk($sformatf("tbl%0d drive", i), drive_enable, (tbl[i].exp_state == 1) ? 1 : 0);
      chk($sformatf("tbl%0d close", i), target_close, (tbl[i].exp_state == 2) ? 1 : 0);
    end

    clear_with_edge(20000);
    frame_chk("post_clr_discard", 8000, 1);
    frame_chk("post_clr_first", 8000, 1);

    for (int n = 0; n < 60; n++) begin
      int pick, cnt;
      r = $urandom_range(0, 11);
      pick = $urandom_range(0, 3);
      case (pick)
        0: cnt = $urandom_range(0, 300);
        1: cnt = $urandom_range(3000, 7000);
        2: cnt = $urandom_range(9000, 16000);
        default: cnt = $urandom_range(0, 131071);
      endcase
      if (r == 0) do_clear();
      else if (r == 1) clear_with_edge(cnt);
      else frame_chk($sformatf("rnd%0d", n), cnt, $urandom_range(1, 4));
    end

    // Stall fallback from TRACK, then stale recovery
    do_clear();
    for (int i = 0; i < 6; i++) frame_chk($sformatf("to_fill%0d", i), 8000, 1);
    chk("to_pre state", state, 1);
    begin
      int g = 0;
      while (since < TO - 1 && g < 2 * TO) begin
        @(negedge clk);
        g++;
      end
    end
    chk("to_wait since", since, TO - 1);
    chk("to_edge stale", stale, 0);
    chk("to_edge state", state, 1);
    @(negedge clk);
    model_wipe();
    m_stale = 1;
    check_outputs("timeout");
    do_clear();
    frame_chk("stale_discard", 8000, 1);
    frame_chk("stale_recover", 8000, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/colour_frame_tracker.md
# colour_frame_tracker

Downstream consumer of the per-frame colour pixel count from the colour detection stage. It samples the completed count on each start-of-frame, smooths it over a 4-frame moving average and runs a hysteresis/confirmation state machine. The state machine classifies the selected-colour target as absent, tracked or close, and its outputs drive the motor controller's enable and stop decisions.

## Interface
Parameters:
- `LOST_THRESH`, default 200: average below this counts as target lost.
- `FAR_THRESH`, default 4800: average at or above this counts as target acquired.
- `NEAR_THRESH`, default 9600: average at or above this counts as target close.
- `CONFIRM_FRAMES`, default 3: number of consecutive qualifying averages required before any state transition (1..15).
- `TIMEOUT_CYCLES`, default 2_000_000: clock cycles without a new frame before the stall fallback.
- Legal parameter set requires `LOST_THRESH < FAR_THRESH < NEAR_THRESH`, all below 2^17.

Ports:
- `clk` in 1: system clock, single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `sop` in 1: start-of-packet from the camera path; may stay high for more than one cycle.
- `colour_pixels` in 17: running count from colour detection. It is cleared on the edge after `sop` is sampled high.
- `clear` in 1: single-cycle pulse issued when the selected colour or threshold changes.
- `avg_pixels` out 17: 4-frame moving average.
- `avg_valid` out 1: one-cycle pulse when `avg_pixels` updates.
- `state` out 2: `SEARCH`=0, `TRACK`=1, `CLOSE`=2.
- `target_seen` out 1: `state != SEARCH`.
- `target_close` out 1: `state == CLOSE`.
- `drive_enable` out 1: `state == TRACK`.
- `stale` out 1: camera-stall indicator.

## Operation
- **Frame edge.** A frame edge is `sop` high in this cycle and low in the previous cycle. In that cycle `colour_pixels` holds the previous frame's final count, and that value is sampled.
- **First frame discard.** The first frame edge after `reset` or `clear` is not sampled, because it closes a partial frame. It still restarts the timeout counter.
- **Window.** Four 17-bit slots, shifted on each accepted sample. Slots are zeroed by reset, `clear` or timeout, so the average ramps up over the first 4 frames.
- **Averaging.** `sum` is the 19-bit sum of the 4 slots. `avg_pixels = sum[18:2]`, truncated, never saturated.
- **FSM.** Evaluated only on an `avg_valid` cycle:
  - `SEARCH` → `TRACK` when avg ≥ `FAR_THRESH`.
  - `TRACK` → `CLOSE` when avg ≥ `NEAR_THRESH`.
  - `TRACK` → `SEARCH` when avg < `LOST_THRESH`.
  - `CLOSE` → `TRACK` when avg < `FAR_THRESH`.
  - `CLOSE` never goes directly to `SEARCH`.
- **Confirmation.**
  - A 4-bit `confirm` counter increments on each `avg_valid` whose avg meets the same candidate transition as the previous one.
  - The counter resets to 1 when the candidate changes, and to 0 when no candidate is met.
  - The transition is taken when `confirm` reaches `CONFIRM_FRAMES`. `confirm` is then cleared.
- **Timeout.** A cycle counter restarts on every frame edge. On reaching `TIMEOUT_CYCLES` it:
  - forces `state=SEARCH`;
  - clears the window and `confirm`;
  - sets `stale=1` and holds the counter.
  - `stale` clears on the next accepted sample.
- **Clear.** `clear` forces `SEARCH`, zeroes the window, `confirm` and `avg_pixels`, rearms the first-frame discard, and does not touch `stale`.
- **Simultaneous events.**
  - `clear` with a frame edge in the same cycle: clear wins, and the sample is discarded.
  - Timeout with a frame edge in the same cycle: the frame edge wins, and no timeout occurs.
- **Reset values.** All outputs 0: `state=SEARCH`, `avg_valid=0`, `stale=0`. Reset or `clear` mid-average discards any in-flight sample.

## Timing
- Frame edge sampled in cycle N. Window updated at the end of N.
- `avg_pixels` and `avg_valid` are registered and visible in cycle N+1.
- `state`, `target_seen`, `target_close` and `drive_enable` are visible in cycle N+2.
- All outputs are registered; no combinational path from input to output.
- At most one sample per frame edge. A `sop` held high for multiple cycles yields exactly one sample.
- Minimum frame spacing: 3 cycles.

## Structure
- **Shared package `colour_track_pkg`:**
  - `track_state_t` enum (`SEARCH`, `TRACK`, `CLOSE`);
  - `PIX_W=17`;
  - `SUM_W=19`;
  - candidate-transition encoding.
- **Sub-module `frame_avg4`:** window shift register, sum and registered average with a valid pulse. Its ports are `clk`, `reset`, `clear`, `sample_en`, `sample`, `avg`, `avg_valid`.
- **Top level:** edge detection, discard flag, timeout counter, FSM and output decode.

## Test plan
- **Reset, then discard, then fill.** Reset, then frame edges with count 8000 each. First edge ignored. `avg_pixels` goes 2000, 4000, 6000, 8000. `state` reaches `TRACK` 2 frames after avg first ≥ 4800, with `CONFIRM_FRAMES=3`. `drive_enable=1`.
- **Hysteresis.** In `CLOSE`, feed counts alternating 9000/5000 so the average is ≈7000. State stays `CLOSE`, with no chatter to `TRACK`.
- **Confirmation reset.** In `TRACK`, feed avg ≥ 9600 for 2 frames, then 1 frame at 6000, then ≥ 9600. `CLOSE` is entered only after 3 new consecutive qualifying frames.
- **Long `sop`.** `sop` held high 5 cycles. Exactly one `avg_valid` pulse and one window shift.
- **Timeout.** No `sop` for `TIMEOUT_CYCLES` while in `TRACK`. `state=SEARCH`, `stale=1`, `avg_pixels` cleared to 0 at the next update. A subsequent sampled frame clears `stale`.
- **Clear with frame edge.** Frame edge and `clear` in the same cycle while in `CLOSE`. `state=SEARCH` 1 cycle later. No `avg_valid` pulse. The next frame edge is discarded.
